// File: rtl/neocore_pkg.sv
// Shared fetch-path types and widths for the neocore front end.
package neocore_pkg;

  localparam int unsigned PC_W            = 32;
  localparam int unsigned CNT_W           = 32;
  localparam int unsigned FETCH_BYTES_DEF = 4;

  typedef enum logic {
    RS_RUN,
    RS_PEND
  } redirect_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC register: sequential increment after each completed fetch, or load on redirect.
module fetch_pc_gen
  import neocore_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int unsigned     FETCH_BYTES = FETCH_BYTES_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_pc_i,
  input  logic            inc_i,
  output logic [PC_W-1:0] pc_o
);

  localparam logic [PC_W-1:0] PC_INC = PC_W'(FETCH_BYTES);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Redirect load has priority; the add wraps naturally modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch redirect: owns the fetch handshake, flushes on taken branches, parks redirects behind outstanding fetches.
// Optional taken-redirect counter enabled by NEOCORE_REDIRECT_STATS_EN.
module fetch_redirect_unit
  import neocore_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned     FETCH_BYTES = FETCH_BYTES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             resolve_valid,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_pc,
  input  logic             stall_in,
  output logic             fetch_req,
  output logic [PC_W-1:0]  fetch_pc,
  input  logic             fetch_ack,
  output logic             fetch_discard,
  output logic             flush_o,
  output logic [CNT_W-1:0] redirect_count
);

  redirect_state_e state_q, state_d;
  logic            fetch_req_q, fetch_req_d;
  logic            flush_q, flush_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  logic            pc_load, pc_inc;
  logic [PC_W-1:0] pc_load_val;
  logic            discard_c;
  logic            taken, done;

  assign taken = resolve_valid && branch_taken;
  assign done  = fetch_req_q && fetch_ack;

  fetch_pc_gen #(
    .RESET_PC   (RESET_PC),
    .FETCH_BYTES(FETCH_BYTES)
  ) u_pc_gen (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (pc_load),
    .load_pc_i(pc_load_val),
    .inc_i    (pc_inc),
    .pc_o     (fetch_pc)
  );

  always_comb begin
    state_d     = state_q;
    fetch_req_d = fetch_req_q;
    flush_d     = taken;
    pend_pc_d   = pend_pc_q;
    pc_load     = 1'b0;
    pc_load_val = branch_pc;
    pc_inc      = 1'b0;
    discard_c   = 1'b0;
    case (state_q)
      RS_RUN: begin
        if (taken) begin
          if (!fetch_req_q || fetch_ack) begin
            pc_load     = 1'b1;
            fetch_req_d = !stall_in;
            discard_c   = done;
          end else begin
            // Request in flight keeps its address; target waits for the ack.
            pend_pc_d = branch_pc;
            state_d   = RS_PEND;
          end
        end else if (done) begin
          pc_inc      = 1'b1;
          fetch_req_d = !stall_in;
        end else if (!fetch_req_q) begin
          fetch_req_d = !stall_in;
        end
      end
      RS_PEND: begin
        if (done) begin
          discard_c   = 1'b1;
          pc_load     = 1'b1;
          pc_load_val = taken ? branch_pc : pend_pc_q;
          state_d     = RS_RUN;
          fetch_req_d = !stall_in;
        end else if (taken) begin
          pend_pc_d = branch_pc;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RS_RUN;
      fetch_req_q <= 1'b0;
      flush_q     <= 1'b0;
      pend_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      fetch_req_q <= fetch_req_d;
      flush_q     <= flush_d;
      pend_pc_q   <= pend_pc_d;
    end
  end

  assign fetch_req     = fetch_req_q;
  assign flush_o       = flush_q;
  assign fetch_discard = discard_c;

`ifdef NEOCORE_REDIRECT_STATS_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (taken && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign redirect_count = count_q;
`else
  assign redirect_count = '0;
`endif

endmodule
